// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state and error-code definitions for the PRAM boot loader
package boot_pkg;

   // Loader sequencing: header read, length check, per-byte read/write, checksum check.
   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      RD_LEN_LO = 4'd1,
      RD_LEN_HI = 4'd2,
      CHK_LEN   = 4'd3,
      RD_BYTE   = 4'd4,
      WRITE     = 4'd5,
      RD_CSUM   = 4'd6,
      VERIFY    = 4'd7,
      DONE      = 4'd8,
      ERROR     = 4'd9
   } state_e;

   // Status reported on err_code.
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_LEN     = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT = 2'b10;
   localparam logic [1:0] ERR_CSUM    = 2'b11;

endpackage

// File: rtl/btn_sync_edge.sv
// rtl/btn_sync_edge.sv - two-flop synchronizer with registered rising-edge pulse
module btn_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic pulse_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic pulse_q;

   // Synchronize the raw button, then emit one registered pulse per rising edge (3 cycles pin-to-pulse).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q  <= 1'b0;
         sync_q  <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         meta_q  <= btn_i;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         pulse_q <= sync_q & ~prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/pram_boot_loader.sv
// rtl/pram_boot_loader.sv - loads a length-prefixed, checksummed image from flash into PRAM
module pram_boot_loader
   import boot_pkg::*;
#(
   parameter int                     PRAM_DEPTH  = 512,
   parameter int                     PRAM_AW     = 9,
   parameter int                     FLASH_AW    = 16,
   parameter logic [FLASH_AW-1:0]    IMG_BASE    = '0,
   parameter int                     TIMEOUT_CYC = 65535
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start_btn,
   output logic                flash_req,
   output logic [FLASH_AW-1:0] flash_addr,
   input  logic [7:0]          flash_data,
   input  logic                flash_valid,
   output logic                pram_we,
   output logic [PRAM_AW-1:0]  pram_addr,
   output logic [7:0]          pram_data,
   output logic                cpu_rst,
   output logic                busy,
   output logic                load_done,
   output logic [1:0]          err_code
);

   localparam int             TMO_W   = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);
   localparam logic [15:0]    LEN_MAX = 16'(PRAM_DEPTH);

   logic start_p;

   state_e                state_q, state_d;
   logic                  wait_q, wait_d;
   logic [FLASH_AW-1:0]   flash_addr_q, flash_addr_d;
   logic [15:0]           len_q, len_d;
   logic [15:0]           count_q, count_d;
   logic [7:0]            sum_q, sum_d;
   logic [7:0]            csum_q, csum_d;
   logic [PRAM_AW-1:0]    pram_addr_q, pram_addr_d;
   logic [7:0]            pram_data_q, pram_data_d;
   logic [TMO_W-1:0]      tmo_q, tmo_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [1:0]            err_q, err_d;
   logic                  flash_req_c;
   logic                  pram_we_c;

   btn_sync_edge u_start_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_i   (start_btn),
      .pulse_o (start_p)
   );

   // State and datapath registers; reset parks the CPU in reset with no transaction pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         wait_q       <= 1'b0;
         flash_addr_q <= IMG_BASE;
         len_q        <= '0;
         count_q      <= '0;
         sum_q        <= '0;
         csum_q       <= '0;
         pram_addr_q  <= '0;
         pram_data_q  <= '0;
         tmo_q        <= '0;
         cpu_rst_q    <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= ERR_NONE;
      end else begin
         state_q      <= state_d;
         wait_q       <= wait_d;
         flash_addr_q <= flash_addr_d;
         len_q        <= len_d;
         count_q      <= count_d;
         sum_q        <= sum_d;
         csum_q       <= csum_d;
         pram_addr_q  <= pram_addr_d;
         pram_data_q  <= pram_data_d;
         tmo_q        <= tmo_d;
         cpu_rst_q    <= cpu_rst_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   // Next-state and strobe decode. Each flash read state issues one request, then waits
   // (wait_q=1) for flash_valid or the timeout; strobes seen outside that wait are ignored.
   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      flash_addr_d = flash_addr_q;
      len_d        = len_q;
      count_d      = count_q;
      sum_d        = sum_q;
      csum_d       = csum_q;
      pram_addr_d  = pram_addr_q;
      pram_data_d  = pram_data_q;
      tmo_d        = tmo_q;
      cpu_rst_d    = cpu_rst_q;
      busy_d       = busy_q;
      done_d       = done_q;
      err_d        = err_q;
      flash_req_c  = 1'b0;
      pram_we_c    = 1'b0;

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start_p) begin
               cpu_rst_d    = 1'b1;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               err_d        = ERR_NONE;
               sum_d        = '0;
               count_d      = '0;
               wait_d       = 1'b0;
               flash_addr_d = IMG_BASE;
               state_d      = RD_LEN_LO;
            end
         end

         RD_LEN_LO, RD_LEN_HI, RD_BYTE, RD_CSUM: begin
            if (!wait_q) begin
               flash_req_c = 1'b1;
               wait_d      = 1'b1;
               tmo_d       = TMO_W'(1);
            end else if (flash_valid) begin
               wait_d       = 1'b0;
               flash_addr_d = flash_addr_q + 1'b1;
               case (state_q)
                  RD_LEN_LO: begin
                     len_d[7:0] = flash_data;
                     state_d    = RD_LEN_HI;
                  end
                  RD_LEN_HI: begin
                     len_d[15:8] = flash_data;
                     state_d     = CHK_LEN;
                  end
                  RD_BYTE: begin
                     pram_addr_d = count_q[PRAM_AW-1:0];
                     pram_data_d = flash_data;
                     state_d     = WRITE;
                  end
                  default: begin
                     csum_d  = flash_data;
                     state_d = VERIFY;
                  end
               endcase
            end else if (tmo_q == TMO_MAX) begin
               wait_d  = 1'b0;
               err_d   = ERR_TIMEOUT;
               busy_d  = 1'b0;
               state_d = ERROR;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end

         CHK_LEN: begin
            if (len_q == 16'd0 || len_q > LEN_MAX) begin
               err_d   = ERR_LEN;
               busy_d  = 1'b0;
               state_d = ERROR;
            end else begin
               state_d = RD_BYTE;
            end
         end

         WRITE: begin
            pram_we_c = 1'b1;
            sum_d     = sum_q + pram_data_q;
            count_d   = count_q + 16'd1;
            state_d   = (count_d == len_q) ? RD_CSUM : RD_BYTE;
         end

         VERIFY: begin
            busy_d = 1'b0;
            if (csum_q == sum_q) begin
               cpu_rst_d = 1'b0;
               done_d    = 1'b1;
               state_d   = DONE;
            end else begin
               err_d   = ERR_CSUM;
               state_d = ERROR;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign flash_req  = flash_req_c;
   assign flash_addr = flash_addr_q;
   assign pram_we    = pram_we_c;
   assign pram_addr  = pram_addr_q;
   assign pram_data  = pram_data_q;
   assign cpu_rst    = cpu_rst_q;
   assign busy       = busy_q;
   assign load_done  = done_q;
   assign err_code   = err_q;

endmodule
